// File: rtl/wb_intercon.sv
// Shared-bus Wishbone interconnect: two masters, round-robin arbitration,
// address decode to up to eight slaves, unmapped-address error and bus watchdog.
module wb_intercon #(
    parameter int                             NUM_SLAVES     = 6,
    parameter int                             S_ADDR_W       = 4,
    parameter logic [NUM_SLAVES*S_ADDR_W-1:0] S_ADDR_MAP     = 24'h654320,
    parameter logic [15:0]                    TIMEOUT_CYCLES = 16'd255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              m0_adr_i,
    input  logic [31:0]              m1_adr_i,
    input  logic [31:0]              m0_dat_i,
    input  logic [31:0]              m1_dat_i,
    output logic [31:0]              m0_dat_o,
    output logic [31:0]              m1_dat_o,
    input  logic [3:0]               m0_sel_i,
    input  logic [3:0]               m1_sel_i,
    input  logic                     m0_we_i,
    input  logic                     m1_we_i,
    input  logic                     m0_cyc_i,
    input  logic                     m1_cyc_i,
    input  logic                     m0_stb_i,
    input  logic                     m1_stb_i,
    output logic                     m0_ack_o,
    output logic                     m1_ack_o,
    output logic                     m0_err_o,
    output logic                     m1_err_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    output logic [3:0]               s_sel_o,
    output logic                     s_we_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    input  logic [32*NUM_SLAVES-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    output logic [1:0]               grant_o,
    output logic                     timeout_o
);

    typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1, ERR} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;   // 0 = m0, 1 = m1; valid in OWN_Mx and ERR
    logic        last_q, last_d;     // master that most recently released the bus
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    logic                  in_own;
    logic                  own_cyc, own_stb, own_we;
    logic [31:0]           own_adr, own_dat;
    logic [3:0]            own_sel;
    logic [NUM_SLAVES-1:0] sel_oh;
    logic                  hit, slv_ack, bus_ack;
    logic [31:0]           slv_dat;

    always_comb begin : owner_mux
        in_own  = (state_q == OWN_M0) || (state_q == OWN_M1);
        own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
        own_stb = owner_q ? m1_stb_i : m0_stb_i;
        own_we  = owner_q ? m1_we_i  : m0_we_i;
        own_adr = owner_q ? m1_adr_i : m0_adr_i;
        own_dat = owner_q ? m1_dat_i : m0_dat_i;
        own_sel = owner_q ? m1_sel_i : m0_sel_i;
    end

    // Ascending scan with an early-out flag so the lowest-indexed duplicate wins.
    always_comb begin : decode
        sel_oh  = '0;
        hit     = 1'b0;
        slv_dat = '0;
        slv_ack = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && (own_adr[31 -: S_ADDR_W] == S_ADDR_MAP[i*S_ADDR_W +: S_ADDR_W])) begin
                sel_oh[i] = 1'b1;
                hit       = 1'b1;
                slv_dat   = s_dat_i[i*32 +: 32];
                slv_ack   = s_ack_i[i];
            end
        end
        bus_ack = in_own && own_cyc && own_stb && hit && slv_ack;
    end

    always_comb begin : outputs
        s_adr_o   = in_own ? own_adr : '0;
        s_dat_o   = in_own ? own_dat : '0;
        s_sel_o   = in_own ? own_sel : '0;
        s_we_o    = in_own && own_we;
        s_cyc_o   = (in_own && own_cyc) ? sel_oh : '0;
        s_stb_o   = (in_own && own_cyc && own_stb) ? sel_oh : '0;
        m0_ack_o  = bus_ack && !owner_q;
        m1_ack_o  = bus_ack && owner_q;
        m0_err_o  = (state_q == ERR) && !owner_q;
        m1_err_o  = (state_q == ERR) && owner_q;
        m0_dat_o  = (in_own && !owner_q) ? slv_dat : '0;
        m1_dat_o  = (in_own && owner_q) ? slv_dat : '0;
        grant_o   = (in_own || state_q == ERR) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        timeout_o = timeout_q;
    end

    always_comb begin : next_state
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = OWN_M0;
                    owner_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = OWN_M1;
                    owner_d = 1'b1;
                end
            end
            OWN_M0, OWN_M1: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (own_stb && !hit) begin
                    state_d = ERR;
                    cnt_d   = '0;
                end else if (own_stb && !bus_ack) begin
                    // An ack on the expiry cycle takes the other branch, so ack beats timeout.
                    if (TIMEOUT_CYCLES != 16'd0 && cnt_q == TIMEOUT_CYCLES) begin
                        state_d   = ERR;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else if (TIMEOUT_CYCLES != 16'd0) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ERR: begin
                state_d = owner_q ? OWN_M1 : OWN_M0;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: doc/wb_intercon.md
# wb_intercon

Parametrised shared-bus Wishbone interconnect for the LM32 SoC. It connects the two CPU masters (m0 instruction, m1 data) to up to eight slaves. It adds round-robin arbitration, an error response for unmapped addresses, and a bus-watchdog timeout. It sits between `lm32_cpu` and the peripherals (bram, uart, timer, gpio, keypad, SK6812RGBW), and lets slaves be added without editing the interconnect.

## Interface
Parameters:
- `NUM_SLAVES`, 6: number of slave ports, legal 1..8.
- `S_ADDR_W`, 4: number of address MSBs decoded per slave.
- `S_ADDR_MAP`, 24'h654320: packed slave bases, `S_ADDR_W` bits each; slave i occupies bits [i*S_ADDR_W +: S_ADDR_W]. The default places slave0 at 0x0, slave1 at 0x2, … slave5 at 0x6.
- `TIMEOUT_CYCLES`, 255: wait cycles without ack before an error is returned; 0 disables the watchdog. Width is 16 bits.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-low reset.
- `m0_adr_i`, `m1_adr_i` in 32: master address.
- `m0_dat_i`, `m1_dat_i` in 32: master write data.
- `m0_dat_o`, `m1_dat_o` out 32: read data.
- `m0_sel_i`, `m1_sel_i` in 4: byte selects.
- `m0_we_i`, `m1_we_i` in 1: write enable.
- `m0_cyc_i`, `m1_cyc_i` in 1: cycle.
- `m0_stb_i`, `m1_stb_i` in 1: strobe.
- `m0_ack_o`, `m1_ack_o` out 1: acknowledge.
- `m0_err_o`, `m1_err_o` out 1: error termination.
- `s_adr_o` out 32: shared slave address.
- `s_dat_o` out 32: shared slave write data.
- `s_sel_o` out 4: shared byte selects.
- `s_we_o` out 1: shared write enable.
- `s_cyc_o` out NUM_SLAVES: per-slave cycle.
- `s_stb_o` out NUM_SLAVES: per-slave strobe.
- `s_dat_i` in 32*NUM_SLAVES: packed slave read data; slave i is [i*32 +: 32].
- `s_ack_i` in NUM_SLAVES: per-slave acknowledge.
- `grant_o` out 2: one-hot current owner; bit0 = m0, bit1 = m1.
- `timeout_o` out 1: one-cycle pulse on a watchdog expiry.

## Operation
- **FSM states:** IDLE, OWN_M0, OWN_M1, ERR.
- **IDLE:**
  - Only one `cyc` high: that master is granted next edge.
  - Both `cyc` high: the master not granted last wins.
  - `last` pointer reset value = m1, so m0 wins the first tie.
- **OWN_Mx:**
  - Grant is held while `mx_cyc_i` is high.
  - `cyc` low → IDLE next edge; `last` ← x.
  - The other master's requests wait; its `ack`/`err` stay 0.
- **Decode:** combinational on the granted master's `adr[31:32-S_ADDR_W]` against each `S_ADDR_MAP` entry.
  - Duplicate entries: lowest index wins.
  - Only the selected slave gets `s_cyc_o`/`s_stb_o`, copied from the owner's `cyc`/`stb`.
- **Shared outputs:** `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o` are muxed from the owner; all zero in IDLE and ERR.
- **Read/ack path:**
  - Owner `dat_o` = selected slave's `s_dat_i`; non-owner `dat_o` = 0.
  - Owner `ack_o` = selected slave's `s_ack_i`, passed through combinationally.
- **Unmapped address:**
  - Owner `stb` high with no decode match → ERR next edge.
  - ERR asserts the owner's `err_o` for exactly one cycle, drives no slave, then returns to OWN_Mx.
- **Watchdog:**
  - A 16-bit counter increments each cycle the owner has `stb` high with a mapped slave and no ack.
  - It clears on ack, on `stb` low, or on a grant change.
  - Counter reaching `TIMEOUT_CYCLES` → ERR next edge; `timeout_o` pulses in the same cycle as `err_o`.
  - `s_cyc_o`/`s_stb_o` drop during ERR, which aborts the slave cycle.
- **Exclusivity:** `ack_o` and `err_o` are never high together. A slave ack arriving on the expiry edge wins: ack, no error.

## Timing
- **Reset values:** state IDLE, `last` = m1, counter 0. All outputs 0: `grant_o`=2'b00, all `ack`/`err`, `s_cyc_o`/`s_stb_o`, `timeout_o`, all data/address.
- **Reset mid-transaction:** the grant drops at that edge and slave strobes fall the same cycle. There is no `ack`/`err` to the aborted master.
- **Arbitration latency:** `cyc` rising in IDLE at edge n → `grant_o` and `s_stb_o` valid after edge n+1.
- **Back-to-back transfers:** while the grant is held, each new `stb` reaches the slave in 0 cycles.
- **Ack path:** 0 cycles (combinational slave→master).
- **Unmapped error:** `stb` at cycle k (owned) → `err_o` high in cycle k+1 only.
- **Timeout:** with `TIMEOUT_CYCLES` = T, `err_o` rises T+1 cycles after the first unacknowledged `stb` cycle.
- **Handover:** owner drops `cyc` at edge n → other master granted at edge n+2 (IDLE for one cycle).

## Test plan
- **Single master:** m1 reads 0x20000004 with slave1 acking on its first `stb` cycle.
  - Expect `grant_o`=2'b10 one edge after `cyc`, `s_stb_o`=6'b000010, and m1 receiving slave1 data with `ack` the same cycle.
- **Tie:** m0 and m1 raise `cyc` on the same edge after reset.
  - Expect m0 granted first.
  - After m0 drops `cyc`, m1 is granted 2 edges later.
  - On the next tie, m1 loses.
- **Unmapped:** m1 accesses 0xF0000000.
  - Expect no `s_stb_o`, `m1_err_o` high for exactly 1 cycle, `m1_ack_o` 0 throughout.
- **Timeout:** with `TIMEOUT_CYCLES`=4, the slave never acks.
  - Expect `err_o` and `timeout_o` 5 cycles after `stb`, `s_stb_o` low during ERR, counter cleared afterwards.
- **Reset:** `rst` low for 1 cycle mid-read.
  - Expect all outputs 0 after that edge, state IDLE, and m0 winning the next tie.
- **Parametrisation:** `NUM_SLAVES`=8 with duplicate map entries 3 and 5.
  - Expect accesses to route to slave 3 only.
